// File: rtl/opstream_pkg.sv
// -----------------------------------------------------------------------------
// opstream_pkg
//
// Shared definitions for the operand stream memory:
//   state_t    - stream controller states (idle, streaming, draining)
//   BEATCNT_W  - width of the optional transferred-beat counter
//   sat_inc()  - saturating increment used by that counter
// -----------------------------------------------------------------------------
package opstream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BEATCNT_W = 16;

    // Increment that sticks at all-ones instead of rolling over to zero.
    function automatic logic [BEATCNT_W-1:0] sat_inc(input logic [BEATCNT_W-1:0] value);
        return (&value) ? value : value + BEATCNT_W'(1);
    endfunction

endpackage : opstream_pkg

// File: rtl/opstream_ram.sv
// -----------------------------------------------------------------------------
// opstream_ram
//
// Operand-pair storage: DEPTH entries of {a, b}, each 2*WIDTH bits wide.
// One synchronous write port and one combinational (asynchronous) read port.
// Holds storage only; sequencing lives in operand_stream_mem.
//
// Ports:
//   clk    in   rising-edge clock for the write port
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data {a, b}
//   raddr  in   read address
//   rdata  out  read data {a, b}, valid in the same cycle as raddr
// -----------------------------------------------------------------------------
module opstream_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [2*WIDTH-1:0]   wdata,
    input  logic [AW-1:0]        raddr,
    output logic [2*WIDTH-1:0]   rdata
);

    logic [2*WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch on purpose: host-loaded operands must
    // survive a reset, and leaving storage unreset lets it map onto RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : opstream_ram

// File: rtl/operand_stream_mem.sv
// -----------------------------------------------------------------------------
// operand_stream_mem
//
// Writable operand-pair memory that streams (a, b) pairs into the FP multiplier
// datapath over a valid/ready handshake. The host loads entries while idle,
// then a start pulse streams `len` entries (optionally wrapping until stop).
//
// Optional feature (compile-time macro OPSTREAM_BEATCNT_EN):
//   adds output beat_cnt, a saturating count of transferred beats that clears
//   on an accepted start and holds after done.
//
// Parameters:
//   WIDTH  bits per operand (a and b each)
//   DEPTH  number of operand-pair entries, power of two and >= 2
//   AW     address width, derived from DEPTH
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   wr_en      in   memory write strobe (honoured in IDLE only)
//   wr_addr    in   write address
//   wr_a       in   operand a write data
//   wr_b       in   operand b write data
//   start      in   start pulse (honoured in IDLE only)
//   len        in   entries to stream, 0..DEPTH
//   wrap_en    in   restart at entry 0 after len entries until stop
//   stop       in   request to end the stream
//   out_valid  out  output pair valid
//   out_ready  in   consumer ready
//   out_a      out  operand a
//   out_b      out  operand b
//   out_idx    out  entry index of the presented pair
//   busy       out  high while streaming or draining
//   done       out  one-cycle pulse when a stream completes
//   beat_cnt   out  transferred-beat count (only with OPSTREAM_BEATCNT_EN)
// -----------------------------------------------------------------------------
module operand_stream_mem
    import opstream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      wr_a,
    input  logic [WIDTH-1:0]      wr_b,
    input  logic                  start,
    input  logic [AW:0]           len,
    input  logic                  wrap_en,
    input  logic                  stop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_a,
    output logic [WIDTH-1:0]      out_b,
    output logic [AW-1:0]         out_idx,
    output logic                  busy,
    output logic                  done
`ifdef OPSTREAM_BEATCNT_EN
    ,
    output logic [BEATCNT_W-1:0]  beat_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Controller state
    // -------------------------------------------------------------------------
    state_t             state;
    logic [AW-1:0]      ptr;        // next entry to load into the output register
    logic [AW:0]        len_q;      // run length latched at start
    logic               wrap_q;     // wrap mode latched at start

    logic               mem_we;
    logic [2*WIDTH-1:0] rd_data;
    logic               load;       // output register takes mem[ptr] this cycle
    logic               xfer;       // a beat leaves on this edge
    logic               last;       // ptr addresses the final entry of the run

    // Writes only land while idle so the contents never change under a stream.
    assign mem_we = wr_en && (state == ST_IDLE);

    // The output register refills whenever it is empty or being emptied, which
    // gives one beat per cycle with out_ready held high and holds the pair
    // stable while the consumer stalls.
    assign load = (state == ST_RUN) && (!out_valid || out_ready);
    assign xfer = out_valid && out_ready;
    assign last = ({1'b0, ptr} == (len_q - (AW+1)'(1)));

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    opstream_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata ({wr_a, wr_b}),
        .raddr (ptr),
        .rdata (rd_data)
    );

    // -------------------------------------------------------------------------
    // Stream FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would let later statements see
    // half-updated state and the result would depend on statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            len_q     <= '0;
            wrap_q    <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless a branch below raises it.
            done <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        wrap_q <= wrap_en;
                        ptr    <= '0;
                        if (len == '0) begin
                            // Empty run: nothing to stream, complete at once.
                            done <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (load) begin
                        out_a     <= rd_data[2*WIDTH-1:WIDTH];
                        out_b     <= rd_data[WIDTH-1:0];
                        out_idx   <= ptr;
                        out_valid <= 1'b1;
                        if (last) begin
                            if (wrap_q) begin
                                ptr <= '0;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                    // A stop coinciding with a load lets that load finish; the
                    // freshly loaded pair is then drained like any other.
                    if (stop) begin
                        state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    // Wait for the pair still in the output register to leave.
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Optional transferred-beat counter
    // -------------------------------------------------------------------------
`ifdef OPSTREAM_BEATCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= '0;
        end else if ((state == ST_IDLE) && start) begin
            // Transfers never occur in IDLE, so clearing here cannot drop a beat.
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= sat_inc(beat_cnt);
        end
    end
`else
    // Without the counter the transfer strobe has no consumer.
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

endmodule : operand_stream_mem

// File: tb/tb_operand_stream_mem.sv
// -----------------------------------------------------------------------------
// tb_operand_stream_mem
//
// Self-checking bench for operand_stream_mem. A plain array mirrors the memory
// contents written by the host; each stream is checked against the sequence
// that array and the run rules imply (index = beat number modulo len).
// Define OPSTREAM_BEATCNT_EN for both bench and RTL to cover beat_cnt.
// -----------------------------------------------------------------------------
module tb_operand_stream_mem;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic               clk;
    logic               reset_n;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [WIDTH-1:0]   wr_a;
    logic [WIDTH-1:0]   wr_b;
    logic               start;
    logic [AW:0]        len;
    logic               wrap_en;
    logic               stop;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_a;
    logic [WIDTH-1:0]   out_b;
    logic [AW-1:0]      out_idx;
    logic               busy;
    logic               done;
`ifdef OPSTREAM_BEATCNT_EN
    logic [15:0]        beat_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference copy of the memory: {a, b} per entry.
    logic [2*WIDTH-1:0] model_mem [DEPTH];

    operand_stream_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .start     (start),
        .len       (len),
        .wrap_en   (wrap_en),
        .stop      (stop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
`ifdef OPSTREAM_BEATCNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Load every entry; entries 0 and 7 carry fixed operand values.
    task automatic load_all();
        for (int i = 0; i < DEPTH; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = $urandom();
            b = $urandom();
            if (i == 0) begin a = 32'h3fc4d2a5; b = 32'h3fc4d2a5; end
            if (i == 7) begin a = 32'h3c546f32; b = 32'h3effd8b0; end
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_a    = a;
            wr_b    = b;
            model_mem[i] = {a, b};
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Run one stream.
    //   n          run length
    //   w          wrap mode
    //   mode       0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
    //   stop_after raise stop together with this transfer number (-1: never)
    //   poke       mid-run, try a start and a write that must both be ignored
    task automatic stream(input int n, input bit w, input int mode,
                          input int stop_after, input bit poke);
        int               beats;
        int               exp_idx;
        bit               got_done;
        bit               stalled;
        logic [WIDTH-1:0] held_a;
        logic [WIDTH-1:0] held_b;
        logic [AW-1:0]    held_idx;
        beats    = 0;
        got_done = 1'b0;
        stalled  = 1'b0;
        held_a   = '0;
        held_b   = '0;
        held_idx = '0;

        @(negedge clk);
        start   = 1'b1;
        len     = (AW+1)'(n);
        wrap_en = w;

        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;

            if (cyc == 0) begin
                check("busy_after_start", 64'(busy), 64'(n != 0));
                check("valid_latency0", 64'(out_valid), 64'(0));
                if (n == 0) check("len0_done_next", 64'(done), 64'(1));
`ifdef OPSTREAM_BEATCNT_EN
                check("beat_cnt_cleared", 64'(beat_cnt), 64'(0));
`endif
            end
            if (cyc == 1 && n != 0) check("valid_latency1", 64'(out_valid), 64'(1));

            if (poke && cyc == 3) begin
                start   = 1'b1;
                len     = '0;
                wr_en   = 1'b1;
                wr_addr = AW'(2);
                wr_a    = ~model_mem[2][2*WIDTH-1:WIDTH];
                wr_b    = ~model_mem[2][WIDTH-1:0];
            end

            // A stalled pair must still be presented unchanged.
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_a",     64'(out_a),     64'(held_a));
                check("stall_b",     64'(out_b),     64'(held_b));
                check("stall_idx",   64'(out_idx),   64'(held_idx));
            end

            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase

            if (done) begin
                got_done = 1'b1;
                check("done_valid_low", 64'(out_valid), 64'(0));
                check("done_busy_low",  64'(busy),      64'(0));
            end else if (out_valid && out_ready) begin
                exp_idx = beats % n;
                check("beat_idx", 64'(out_idx), 64'(exp_idx));
                check("beat_a",   64'(out_a),   64'(model_mem[exp_idx][2*WIDTH-1:WIDTH]));
                check("beat_b",   64'(out_b),   64'(model_mem[exp_idx][WIDTH-1:0]));
                beats++;
                if (beats == stop_after) stop = 1'b1;
            end

            stalled  = out_valid && !out_ready;
            held_a   = out_a;
            held_b   = out_b;
            held_idx = out_idx;
        end

        if (!got_done) check("done_timeout", 64'(0), 64'(1));
        if (stop_after < 0) begin
            check("beat_total", 64'(beats), 64'(n));
        end else begin
            check("beat_total_stop", 64'(beats >= stop_after && beats <= stop_after + 1), 64'(1));
        end
        stop = 1'b0;

        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_busy_low", 64'(busy), 64'(0));
        check("idle_valid_low", 64'(out_valid), 64'(0));
`ifdef OPSTREAM_BEATCNT_EN
        check("beat_cnt_after_done", 64'(beat_cnt), 64'(beats));
`endif
    endtask

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_a      = '0;
        wr_b      = '0;
        start     = 1'b0;
        len       = '0;
        wrap_en   = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_busy",  64'(busy),      64'(0));
        check("rst_done",  64'(done),      64'(0));
        check("rst_a",     64'(out_a),     64'(0));
        check("rst_b",     64'(out_b),     64'(0));
        check("rst_idx",   64'(out_idx),   64'(0));
`ifdef OPSTREAM_BEATCNT_EN
        check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
`endif
        reset_n = 1'b1;

        load_all();

        // Full-throughput run of all entries.
        stream(8, 1'b0, 0, -1, 1'b0);
        // Stall pattern; a start and a write during the run must be ignored.
        stream(8, 1'b0, 1, -1, 1'b1);
        // Wrapping run of 3 ended by stop after 7 transfers.
        stream(3, 1'b1, 0, 7, 1'b0);
        // Empty run.
        stream(0, 1'b0, 0, -1, 1'b0);
        // Random stalls; also confirms the write during RUN left entry 2 intact.
        stream(5, 1'b0, 2, -1, 1'b0);

        // Asynchronous reset while a pair is stalled at the output.
        @(negedge clk);
        start     = 1'b1;
        len       = (AW+1)'(8);
        wrap_en   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_busy",  64'(busy),      64'(0));
        check("mid_rst_done",  64'(done),      64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        check("post_rst_no_done", 64'(done), 64'(0));

        // Contents survive reset.
        stream(8, 1'b0, 2, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_operand_stream_mem
